// File: rtl/dispense_timer.sv
// Ingredient dispense timer: opens one valve for DUR_<code> ticks of TICK_DIV clocks, then pulses t_expired.
// Optional feature: define DISPENSE_ABORT_EN to add an abort input that cuts a running dispense short.
module dispense_timer #(
  parameter int unsigned TICK_DIV = 4,
  parameter logic [7:0]  DUR_1    = 8'd3,
  parameter logic [7:0]  DUR_2    = 8'd5,
  parameter logic [7:0]  DUR_3    = 8'd2,
  parameter logic [7:0]  DUR_4    = 8'd4,
  parameter logic [7:0]  DUR_5    = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_timer,
  input  logic [2:0] ing_type,
`ifdef DISPENSE_ABORT_EN
  input  logic       abort,
`endif
  output logic       t_expired,
  output logic       busy,
  output logic [4:0] valve,
  output logic [7:0] remaining
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [2:0]    code_q, code_d;
  logic [4:0]    valve_q, valve_d;
  logic          t_expired_q, t_expired_d;
  logic          busy_q, busy_d;
  logic          abort_req;

`ifdef DISPENSE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [7:0] dur_of(input logic [2:0] code);
    case (code)
      3'd1:    return DUR_1;
      3'd2:    return DUR_2;
      3'd3:    return DUR_3;
      3'd4:    return DUR_4;
      3'd5:    return DUR_5;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] code);
    case (code)
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b01000;
      3'd5:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    case (state_q)
      IDLE: begin
        if (start_timer) begin
          // A zero duration is handled exactly like an unknown code.
          if (dur_of(ing_type) != 8'd0) begin
            state_d     = RUN;
            code_d      = ing_type;
            remaining_d = dur_of(ing_type);
            presc_d     = '0;
          end else begin
            state_d     = DONE;
            code_d      = 3'd0;
            remaining_d = 8'd0;
          end
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d     = DONE;
          remaining_d = 8'd0;
          presc_d     = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (remaining_q <= 8'd1) begin
            state_d     = DONE;
            remaining_d = 8'd0;
          end else begin
            remaining_d = remaining_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = 3'd0;
      end
      default: begin
        state_d     = IDLE;
        presc_d     = '0;
        remaining_d = 8'd0;
        code_d      = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so they arrive registered.
    valve_d     = (state_d == RUN) ? onehot(code_d) : 5'b00000;
    busy_d      = (state_d != IDLE);
    t_expired_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= 8'd0;
      code_q      <= 3'd0;
      valve_q     <= 5'b00000;
      t_expired_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
      valve_q     <= valve_d;
      t_expired_q <= t_expired_d;
      busy_q      <= busy_d;
    end
  end

  assign t_expired = t_expired_q;
  assign busy      = busy_q;
  assign valve     = valve_q;
  assign remaining = remaining_q;

endmodule

// File: doc/dispense_timer.md
DISPENSE_TIMER -- requirements
Module: dispense_timer

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per dispense tick (range 1..2^16-1).
REQ-002 Parameters DUR_1..DUR_5, defaults 3, 5, 2, 4, 1, dispense ticks for ingredient codes 1..5, 8 bits each; 0 is treated as an invalid code.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start_timer  input  1  request from the controller FSM; sampled only in IDLE.
REQ-006 ing_type  input  3  ingredient code; 1..5 valid, 0/6/7 invalid; sampled with start_timer.
REQ-007 t_expired  output  1  one-cycle pulse returned to the controller FSM when dispensing ends.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 valve  output  5  one-hot; bit (code-1) high while that ingredient dispenses.
REQ-010 remaining  output  8  dispense ticks left, including the current tick; 0 outside RUN.

Function
REQ-011 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-012 IDLE with start_timer=1 and a valid code with nonzero DUR: latch code, remaining<=DUR_code, prescaler<=0, next state RUN.
REQ-013 IDLE with start_timer=1 and an invalid code or DUR=0: next state DONE directly; valve stays 0.
REQ-014 IDLE with start_timer=0: hold state; outputs stay at reset values.
REQ-015 RUN: prescaler counts 0..TICK_DIV-1 and wraps; on wrap, remaining decrements.
REQ-016 RUN with prescaler wrap and remaining=1: next state DONE, remaining<=0.
REQ-017 valve is registered; it equals onehot(latched code) in every RUN cycle and is 0 in all other states.
REQ-018 DONE: t_expired=1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 Latency: start accepted at cycle N with a valid code gives valve high N+1..N+DUR*TICK_DIV and t_expired at N+DUR*TICK_DIV+1.
REQ-020 Invalid code accepted at cycle N gives t_expired at N+1 only.
REQ-021 start_timer in RUN or DONE is ignored, with no queueing.
REQ-022 start_timer held high through DONE is accepted again in the first IDLE cycle after DONE.
REQ-023 ing_type changes during RUN have no effect, because the code is latched.
REQ-024 Prescaler width is ceil(log2(TICK_DIV)), minimum 1; TICK_DIV=1 decrements remaining every cycle.

Reset
REQ-025 rst_n=0 at any rising edge forces IDLE, prescaler=0, remaining=0, valve=0, t_expired=0, busy=0, latched code=0.
REQ-026 Reset during RUN or DONE aborts without emitting t_expired.
REQ-027 start_timer is ignored in the cycle rst_n=0.
REQ-028 The first start can be accepted in the cycle after rst_n returns to 1.

Configuration
REQ-029 Macro DISPENSE_ABORT_EN defined: adds input abort (1 bit).
REQ-030 With DISPENSE_ABORT_EN, abort=1 in RUN forces DONE on the next edge, closes valve, and clears remaining; t_expired pulses in DONE.
REQ-031 With DISPENSE_ABORT_EN, abort in IDLE or DONE is ignored; abort and start_timer together in IDLE accept the start.
REQ-032 Macro DISPENSE_ABORT_EN undefined: the abort port does not exist and behaviour is exactly REQ-011..REQ-024.

Verification
REQ-033 Defaults; start_timer=1, ing_type=1 at cycle 10 -> valve=5'b00001 cycles 11..22; remaining 3,2,1 changing every 4 cycles; t_expired only at cycle 23.
REQ-034 ing_type=6 with start at cycle 5 -> t_expired at cycle 6, valve always 0, busy high at cycle 6 only.
REQ-035 ing_type=5 start; ing_type switched to 2 and start_timer pulsed during RUN -> valve stays 5'b10000 for 4 cycles; single t_expired; second start ignored.
REQ-036 rst_n=0 mid-RUN at cycle 15 of a code-2 dispense -> all outputs 0 at cycle 16; no t_expired ever; new start at cycle 17 accepted.
REQ-037 start_timer held high continuously with code 3 -> back-to-back dispenses, each 8 cycles of valve=5'b00100; t_expired and next acceptance in consecutive cycles.
REQ-038 With DISPENSE_ABORT_EN, abort at RUN cycle 2 of a code-4 dispense -> valve 0 on the next cycle; t_expired next cycle; IDLE after.
